// File: rtl/nav_spike_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : nav_spike_bus_master
// Description : Bus initiator for the neuro-nav SLAM peripheral. Buffers
//               direction/weight spike events in a FIFO, writes each as a
//               spike packet, pulses the integrate control register, and
//               services the peripheral interrupt with write-to-clear.
//               Optional feature macro: NAV_POS_READBACK_EN (reads {Y,X}
//               back from the slave; otherwise a local shadow integrator
//               tracks the position).
// Revision    : 1.0 - initial release
// ============================================================================
module nav_spike_bus_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ev_valid,
    input  logic [1:0]  ev_dir,
    input  logic [15:0] ev_weight,
    output logic        ev_ready,
    output logic [5:0]  m_address,
    output logic [31:0] m_data_in,
    output logic [1:0]  m_data_write_n,
    output logic        m_data_read_n,
    input  logic [31:0] m_data_out,
    input  logic        m_data_ready,
    input  logic        m_irq,
    output logic [15:0] pos_x,
    output logic [15:0] pos_y,
    output logic        pos_valid,
    output logic [7:0]  irq_count,
    output logic        rd_err
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_PKT  = 3'd1,
        S_WR_EN1  = 3'd2,
        S_WR_EN0  = 3'd3,
        S_RD_POS  = 3'd4,
        S_CLR_IRQ = 3'd5
    } state_t;

    state_t      state;
    logic [17:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic [17:0] head;
    logic [1:0]  guard;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign ev_ready   = !fifo_full;
    assign push       = ev_valid && !fifo_full;
    assign head       = fifo_mem[rd_ptr[AW-1:0]];

    // Pop whenever IDLE is free to take an entry: no guard, no pending interrupt.
    always_comb begin
        pop = 1'b0;
        if (state == S_IDLE && guard == 2'd0 && !m_irq && !fifo_empty)
            pop = 1'b1;
    end

    // Event storage; {dir, weight} per entry.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[AW-1:0]] <= {ev_dir, ev_weight};
    end

    // FIFO read/write pointers with wrap bit for full/empty detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

`ifdef NAV_POS_READBACK_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
`else
    logic [1:0]  cur_dir;
    logic [15:0] cur_w;
    logic        unused_rd;
    assign unused_rd     = ^{m_data_out, m_data_ready};
    assign rd_err        = 1'b0;
    assign m_data_read_n = 1'b1;
`endif

    // Bus sequencer: each state is one bus cycle, strobes registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            m_address      <= 6'd0;
            m_data_in      <= 32'd0;
            m_data_write_n <= 2'b11;
            pos_x          <= 16'd0;
            pos_y          <= 16'd0;
            pos_valid      <= 1'b0;
            irq_count      <= 8'd0;
            guard          <= 2'd0;
`ifdef NAV_POS_READBACK_EN
            m_data_read_n  <= 1'b1;
            rd_err         <= 1'b0;
            tcnt           <= '0;
`else
            cur_dir        <= 2'd0;
            cur_w          <= 16'd0;
`endif
        end else begin
            pos_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (guard != 2'd0) begin
                        guard <= guard - 2'd1;
                    end else if (m_irq) begin
                        state          <= S_CLR_IRQ;
                        m_address      <= 6'h0C;
                        m_data_in      <= 32'h1;
                        m_data_write_n <= 2'b00;
                    end else if (!fifo_empty && head[15:0] != 16'd0) begin
                        // Zero-weight entries are popped here and dropped silently.
                        state          <= S_WR_PKT;
                        m_address      <= 6'h00;
                        m_data_in      <= {14'd0, head};
                        m_data_write_n <= 2'b00;
`ifndef NAV_POS_READBACK_EN
                        cur_dir        <= head[17:16];
                        cur_w          <= head[15:0];
`endif
                    end
                end
                S_WR_PKT: begin
                    state     <= S_WR_EN1;
                    m_address <= 6'h04;
                    m_data_in <= 32'h1;
                end
                S_WR_EN1: begin
                    state     <= S_WR_EN0;
                    m_address <= 6'h04;
                    m_data_in <= 32'h0;
                end
                S_WR_EN0: begin
                    m_data_write_n <= 2'b11;
`ifdef NAV_POS_READBACK_EN
                    state          <= S_RD_POS;
                    m_address      <= 6'h08;
                    m_data_read_n  <= 1'b0;
                    tcnt           <= '0;
`else
                    state     <= S_IDLE;
                    pos_valid <= 1'b1;
                    case (cur_dir)
                        2'd0:    pos_x <= pos_x + cur_w;
                        2'd1:    pos_y <= pos_y + cur_w;
                        2'd2:    pos_x <= pos_x - cur_w;
                        default: pos_y <= pos_y - cur_w;
                    endcase
`endif
                end
`ifdef NAV_POS_READBACK_EN
                S_RD_POS: begin
                    if (m_data_ready) begin
                        pos_y         <= m_data_out[31:16];
                        pos_x         <= m_data_out[15:0];
                        pos_valid     <= 1'b1;
                        m_data_read_n <= 1'b1;
                        state         <= S_IDLE;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        rd_err        <= 1'b1;
                        m_data_read_n <= 1'b1;
                        state         <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
`endif
                S_CLR_IRQ: begin
                    m_data_write_n <= 2'b11;
                    state          <= S_IDLE;
                    // Slave needs two cycles before its interrupt line drops.
                    guard          <= 2'd2;
                    if (irq_count != 8'hFF)
                        irq_count <= irq_count + 8'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nav_spike_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_nav_spike_bus_master
// Description : Directed bench for nav_spike_bus_master with a small slave
//               model that logs bus writes and answers position reads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nav_spike_bus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ev_valid;
    logic [1:0]  ev_dir;
    logic [15:0] ev_weight;
    logic        ev_ready;
    logic [5:0]  m_address;
    logic [31:0] m_data_in;
    logic [1:0]  m_data_write_n;
    logic        m_data_read_n;
    logic [31:0] m_data_out;
    logic        m_data_ready;
    logic        m_irq;
    logic [15:0] pos_x;
    logic [15:0] pos_y;
    logic        pos_valid;
    logic [7:0]  irq_count;
    logic        rd_err;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [5:0]  log_a [64];
    logic [31:0] log_d [64];
    int          n_wr;
    int          n_rd_low;
    int          n_pv;
    logic        saw_full;

    always #5 clk = ~clk;

    nav_spike_bus_master #(.FIFO_DEPTH(4), .TIMEOUT(15)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ev_valid       (ev_valid),
        .ev_dir         (ev_dir),
        .ev_weight      (ev_weight),
        .ev_ready       (ev_ready),
        .m_address      (m_address),
        .m_data_in      (m_data_in),
        .m_data_write_n (m_data_write_n),
        .m_data_read_n  (m_data_read_n),
        .m_data_out     (m_data_out),
        .m_data_ready   (m_data_ready),
        .m_irq          (m_irq),
        .pos_x          (pos_x),
        .pos_y          (pos_y),
        .pos_valid      (pos_valid),
        .irq_count      (irq_count),
        .rd_err         (rd_err)
    );

`ifdef NAV_POS_READBACK_EN
    logic        stall;
    logic [15:0] sx;
    logic [15:0] sy;
    logic [17:0] spkt;
    logic        sarm;
    assign m_data_ready = !m_data_read_n && !stall;
    assign m_data_out   = {sy, sx};
`else
    assign m_data_ready = 1'b0;
    assign m_data_out   = 32'd0;
`endif

    // Slave model: log writes, count read strobes and pos_valid pulses, clear irq.
    always @(posedge clk) begin
        if (m_data_write_n == 2'b00) begin
            if (n_wr < 64) begin
                log_a[n_wr] = m_address;
                log_d[n_wr] = m_data_in;
            end
            n_wr = n_wr + 1;
            if (m_address == 6'h0C) m_irq = 1'b0;
`ifdef NAV_POS_READBACK_EN
            if (m_address == 6'h00) spkt = m_data_in[17:0];
            if (m_address == 6'h04 && m_data_in == 32'h1) sarm = 1'b1;
            if (m_address == 6'h04 && m_data_in == 32'h0 && sarm) begin
                sarm = 1'b0;
                case (spkt[17:16])
                    2'd0:    sx = sx + spkt[15:0];
                    2'd1:    sy = sy + spkt[15:0];
                    2'd2:    sx = sx - spkt[15:0];
                    default: sy = sy - spkt[15:0];
                endcase
            end
`endif
        end
        if (!m_data_read_n) n_rd_low = n_rd_low + 1;
        if (pos_valid) n_pv = n_pv + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        ev_valid  = 1'b0;
        ev_dir    = 2'd0;
        ev_weight = 16'd0;
        m_irq     = 1'b0;
`ifdef NAV_POS_READBACK_EN
        stall = 1'b0;
        sx    = 16'd0;
        sy    = 16'd0;
        sarm  = 1'b0;
        spkt  = 18'd0;
`endif
        repeat (2) @(negedge clk);
        n_wr     = 0;
        n_rd_low = 0;
        n_pv     = 0;
        rst_n    = 1'b1;
    endtask

    // Offer one event, holding it until accepted (bounded).
    task automatic push(input logic [1:0] d, input logic [15:0] w);
        int waited;
        waited = 0;
        @(negedge clk);
        ev_valid  = 1'b1;
        ev_dir    = d;
        ev_weight = w;
        while (!ev_ready && waited < 50) begin
            saw_full = 1'b1;
            waited++;
            @(negedge clk);
        end
        if (!ev_ready) check("push_accept", {31'd0, ev_ready}, 32'd1);
        @(posedge clk);
        #1 ev_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        saw_full = 1'b0;
        n_wr = 0; n_rd_low = 0; n_pv = 0;
        do_reset();
        #1;
        check("rst_write_n", {30'd0, m_data_write_n}, 32'h3);
        check("rst_read_n", {31'd0, m_data_read_n}, 32'h1);
        check("rst_addr", {26'd0, m_address}, 32'h0);
        check("rst_data", m_data_in, 32'h0);
        check("rst_pos", {pos_y, pos_x}, 32'h0);
        check("rst_misc", {20'd0, irq_count, pos_valid, rd_err, ev_ready}, 32'h1);

        // E,w=5: exact bus latency
        push(2'd0, 16'd5);
        check("lat_c1_idle", {30'd0, m_data_write_n}, 32'h3);
        step(1);
        check("lat_c2_pkt", {m_data_write_n, m_address, m_data_in[23:0]}, {2'b00, 6'h00, 24'h000005});
        step(1);
        check("lat_c3_en1", {m_data_write_n, m_address, m_data_in[23:0]}, {2'b00, 6'h04, 24'h000001});
        step(1);
        check("lat_c4_en0", {m_data_write_n, m_address, m_data_in[23:0]}, {2'b00, 6'h04, 24'h000000});
        step(1);
`ifdef NAV_POS_READBACK_EN
        check("lat_c5_rd", {30'd0, m_data_read_n, m_data_write_n[0]}, 32'h1);
        check("lat_c5_raddr", {26'd0, m_address}, 32'h8);
        step(1);
`endif
        check("lat_pv", {31'd0, pos_valid}, 32'h1);
        check("lat_pos_x", {16'd0, pos_x}, 32'h5);
        step(20);
        check("lat_writes", n_wr, 3);
        check("lat_pv_count", n_pv, 1);

        // W,w=3 wraps; N,w=2 leaves x
        do_reset();
        push(2'd2, 16'd3);
        step(20);
        check("wrap_x", {pos_y, pos_x}, 32'h0000FFFD);
        push(2'd1, 16'd2);
        step(20);
        check("north_y", {pos_y, pos_x}, 32'h0002FFFD);

        // back-pressure: 8 events offered every cycle
        do_reset();
        saw_full = 1'b0;
        for (int i = 1; i <= 8; i++) push(2'd0, 16'(i));
        step(60);
        check("bp_full_seen", {31'd0, saw_full}, 32'h1);
        check("bp_writes", n_wr, 24);
        for (int i = 0; i < 8; i++) check($sformatf("bp_pkt%0d", i), log_d[3*i], 32'(i + 1));
        check("bp_pos_x", {16'd0, pos_x}, 32'd36);
        check("bp_pv_count", n_pv, 8);
        check("bp_ready_back", {31'd0, ev_ready}, 32'h1);

        // zero-weight dropped
        do_reset();
        push(2'd0, 16'd0);
        push(2'd0, 16'd1);
        step(20);
        check("zw_writes", n_wr, 3);
        check("zw_pos_x", {16'd0, pos_x}, 32'h1);
        check("zw_pv_count", n_pv, 1);

        // interrupt takes priority over queued event
        do_reset();
        push(2'd0, 16'd2);
        m_irq = 1'b1;
        step(20);
        check("irq_first_addr", {26'd0, log_a[0]}, 32'h0C);
        check("irq_first_data", log_d[0], 32'h1);
        check("irq_then_pkt", {26'd0, log_a[1]}, 32'h00);
        check("irq_count", {24'd0, irq_count}, 32'h1);
        check("irq_pos_x", {16'd0, pos_x}, 32'h2);
        check("irq_writes", n_wr, 4);

`ifdef NAV_POS_READBACK_EN
        // read never acknowledged: timeout
        do_reset();
        stall = 1'b1;
        push(2'd1, 16'd4);
        step(40);
        check("to_read_cycles", n_rd_low, 15);
        check("to_rd_err", {31'd0, rd_err}, 32'h1);
        check("to_pos", {pos_y, pos_x}, 32'h0);
        check("to_pv_count", n_pv, 0);
        stall = 1'b0;
`else
        // shadow integrator, no reads ever issued
        do_reset();
        push(2'd3, 16'd4);
        step(20);
        check("sh_read_cycles", n_rd_low, 0);
        check("sh_rd_err", {31'd0, rd_err}, 32'h0);
        check("sh_pos", {pos_y, pos_x}, 32'hFFFC0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
